multiplier: RTL and testbench



---
 rtl/multiplier_pkg.sv | 89 ++++++++
 rtl/multiplier_sincos_lut.sv | 61 ++++++
 rtl/multiplier.sv | 77 +++++++
 tb/tb_multiplier.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared types, widths and constant helpers for the per-lane complex rotator.
// The quarter-wave sine table is generated at elaboration from an integer series.
package mult_pkg;

    localparam int LANES     = 5;
    localparam int DATA_W    = 16;
    localparam int PHASE_W   = 14;
    localparam int COEF_W    = 16;

    localparam int QUAD_W    = 2;
    localparam int IDX_W     = 8;
    localparam int ROM_DEPTH = (1 << IDX_W) + 1;
    localparam int ROM_AW    = IDX_W + 1;

    localparam int PROD_W    = DATA_W + COEF_W;
    localparam int SUM_W     = PROD_W + 1;
    localparam int FRAC_W    = COEF_W - 1;
    localparam int RND_W     = SUM_W - FRAC_W;

    typedef logic signed [DATA_W-1:0]  sample_t;
    typedef logic        [PHASE_W-1:0] phase_t;
    typedef logic signed [COEF_W-1:0]  coef_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [SUM_W-1:0]   sum_t;
    typedef logic signed [RND_W-1:0]   rnd_t;

    typedef sample_t [LANES-1:0] sample_lanes_t;
    typedef phase_t  [LANES-1:0] phase_lanes_t;

    localparam rnd_t SAT_HI     = rnd_t'((2 ** (DATA_W - 1)) - 1);
    localparam rnd_t SAT_LO     = rnd_t'(-(2 ** (DATA_W - 1)));
    localparam sum_t ROUND_BIAS = sum_t'(2 ** (FRAC_W - 1));

    localparam logic [63:0] ONE_Q32     = 64'h0000_0001_0000_0000;
    localparam logic [63:0] HALF_Q32    = 64'h0000_0000_8000_0000;
    localparam logic [63:0] HALF_PI_Q32 = 64'd6746518852;
    localparam logic [63:0] COEF_SCALE  = 64'd32767;

    // round(32767*sin(pi/2*m/256)) in Q32 fixed point; above m=128 the cosine
    // series of the complement angle keeps the argument below pi/4 for accuracy.
    function automatic coef_t quarter_sin(input int m);
        logic [63:0] x;
        logic [63:0] x2;
        logic [63:0] term;
        logic [63:0] sum;
        logic [63:0] scaled;
        logic        use_cos;
        int          a;
        use_cos = (m > 128);
        a       = use_cos ? (256 - m) : m;
        x       = (HALF_PI_Q32 * 64'(a) + 64'd128) >> 8;
        x2      = (x * x) >> 32;
        sum     = use_cos ? ONE_Q32 : x;
        term    = sum;
        for (int k = 1; k <= 8; k++) begin
            term = (term * x2) >> 32;
            if (use_cos) begin
                term = term / 64'((2 * k - 1) * (2 * k));
            end else begin
                term = term / 64'((2 * k) * (2 * k + 1));
            end
            if ((k % 2) == 1) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        scaled = (sum * COEF_SCALE + HALF_Q32) >> 32;
        return coef_t'(scaled[COEF_W-1:0]);
    endfunction

    // Round half up at the Q1.15 point, then clamp into the sample range.
    function automatic sample_t round_sat(input sum_t s);
        sum_t    biased;
        rnd_t    r;
        sample_t y;
        biased = s + ROUND_BIAS;
        r      = rnd_t'(biased >>> FRAC_W);
        if (r > SAT_HI) begin
            y = sample_t'(SAT_HI);
        end else if (r < SAT_LO) begin
            y = sample_t'(SAT_LO);
        end else begin
            y = sample_t'(r);
        end
        return y;
    endfunction

endpackage

// File: rtl/multiplier_sincos_lut.sv
// Phase word to registered sin/cos coefficients: quarter-wave ROM plus
// quadrant folding, one clock of latency.
module sincos_lut
    import mult_pkg::*;
(
    input  logic   clk100,
    input  logic   reset,
    input  phase_t phase_i,
    output coef_t  sin_o,
    output coef_t  cos_o
);

    coef_t rom [ROM_DEPTH];

    generate
        for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
            localparam coef_t ENTRY = quarter_sin(gi);
            assign rom[gi] = ENTRY;
        end
    endgenerate

    logic [QUAD_W-1:0] quad;
    logic [ROM_AW-1:0] k_idx;
    logic [ROM_AW-1:0] k_comp;
    logic              unused_phase_lsbs;

    assign quad              = phase_i[PHASE_W-1 -: QUAD_W];
    assign k_idx             = {1'b0, phase_i[PHASE_W-QUAD_W-1 -: IDX_W]};
    assign k_comp            = ROM_AW'(ROM_DEPTH - 1) - k_idx;
    assign unused_phase_lsbs = ^phase_i[PHASE_W-QUAD_W-IDX_W-1:0];

    coef_t sin_mag;
    coef_t cos_mag;
    coef_t sin_d;
    coef_t cos_d;
    coef_t sin_q;
    coef_t cos_q;

    // Odd quadrants swap the table roles; sin is negative in the lower half
    // plane, cos in the left half plane.
    always_comb begin
        sin_mag = quad[0] ? rom[k_comp] : rom[k_idx];
        cos_mag = quad[0] ? rom[k_idx]  : rom[k_comp];
        sin_d   = quad[1] ? -sin_mag : sin_mag;
        cos_d   = (quad[1] ^ quad[0]) ? -cos_mag : cos_mag;
    end

    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            sin_q <= '0;
            cos_q <= '0;
        end else begin
            sin_q <= sin_d;
            cos_q <= cos_d;
        end
    end

    assign sin_o = sin_q;
    assign cos_o = cos_q;

endmodule

// File: rtl/multiplier.sv
// Five independent lanes rotating (I + jQ) by e^{j*theta}; three-stage
// pipeline: coefficient lookup, products, round/saturate.
module multiplier
    import mult_pkg::*;
(
    input  logic          clk100,
    input  logic          reset,
    input  phase_lanes_t  phase_vals,
    input  sample_lanes_t data_i_in,
    input  sample_lanes_t data_q_in,
    output sample_lanes_t data_i_rot,
    output sample_lanes_t data_q_rot
);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            sample_t i_s1_q;
            sample_t q_s1_q;
            coef_t   sin_s1;
            coef_t   cos_s1;

            prod_t   ic_s2_q;
            prod_t   qs_s2_q;
            prod_t   is_s2_q;
            prod_t   qc_s2_q;

            sum_t    sum_i_d;
            sum_t    sum_q_d;
            sample_t i_rot_d;
            sample_t q_rot_d;
            sample_t i_rot_q;
            sample_t q_rot_q;

            sincos_lut u_lut (
                .clk100  (clk100),
                .reset   (reset),
                .phase_i (phase_vals[gi]),
                .sin_o   (sin_s1),
                .cos_o   (cos_s1)
            );

            always_comb begin
                sum_i_d = sum_t'(ic_s2_q) - sum_t'(qs_s2_q);
                sum_q_d = sum_t'(is_s2_q) + sum_t'(qc_s2_q);
                i_rot_d = round_sat(sum_i_d);
                q_rot_d = round_sat(sum_q_d);
            end

            // The lookup registers inside u_lut share stage 1 with i_s1_q/q_s1_q.
            always_ff @(posedge clk100 or posedge reset) begin
                if (reset) begin
                    i_s1_q  <= '0;
                    q_s1_q  <= '0;
                    ic_s2_q <= '0;
                    qs_s2_q <= '0;
                    is_s2_q <= '0;
                    qc_s2_q <= '0;
                    i_rot_q <= '0;
                    q_rot_q <= '0;
                end else begin
                    i_s1_q  <= data_i_in[gi];
                    q_s1_q  <= data_q_in[gi];
                    ic_s2_q <= prod_t'(i_s1_q) * prod_t'(cos_s1);
                    qs_s2_q <= prod_t'(q_s1_q) * prod_t'(sin_s1);
                    is_s2_q <= prod_t'(i_s1_q) * prod_t'(sin_s1);
                    qc_s2_q <= prod_t'(q_s1_q) * prod_t'(cos_s1);
                    i_rot_q <= i_rot_d;
                    q_rot_q <= q_rot_d;
                end
            end

            assign data_i_rot[gi] = i_rot_q;
            assign data_q_rot[gi] = q_rot_q;
        end
    endgenerate

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the 5-lane complex rotator: directed spec vectors
// plus randomized streams compared against a real-arithmetic reference.
module tb_multiplier;

    localparam int NL = 5;

    logic clk100 = 1'b0;
    logic reset  = 1'b0;
    logic [NL-1:0][13:0] phase_vals;
    logic [NL-1:0][15:0] data_i_in;
    logic [NL-1:0][15:0] data_q_in;
    logic [NL-1:0][15:0] data_i_rot;
    logic [NL-1:0][15:0] data_q_rot;

    int n_checks = 0;
    int n_errors = 0;

    typedef logic [NL-1:0][13:0] ph_vec_t;
    typedef logic [NL-1:0][15:0] dat_vec_t;
    typedef struct packed {
        dat_vec_t ei;
        dat_vec_t eq;
    } exp_t;

    always #5 clk100 = ~clk100;

    multiplier dut (
        .clk100     (clk100),
        .reset      (reset),
        .phase_vals (phase_vals),
        .data_i_in  (data_i_in),
        .data_q_in  (data_q_in),
        .data_i_rot (data_i_rot),
        .data_q_rot (data_q_rot)
    );

    function automatic int rom_s(input int m);
        real r;
        r = 32767.0 * $sin(3.14159265358979324 * real'(m) / 512.0);
        return $rtoi(r + 0.5);
    endfunction

    function automatic logic [15:0] model_rot(input logic [13:0] ph, input logic [15:0] i_raw,
                                              input logic [15:0] q_raw, input bit want_q);
        int     p, quad, k, s, c;
        longint iv, qv, v;
        p    = int'(ph) >> 4;
        quad = p / 256;
        k    = p % 256;
        case (quad)
            0:       begin s =  rom_s(k);       c =  rom_s(256 - k); end
            1:       begin s =  rom_s(256 - k); c = -rom_s(k);       end
            2:       begin s = -rom_s(k);       c = -rom_s(256 - k); end
            default: begin s = -rom_s(256 - k); c =  rom_s(k);       end
        endcase
        iv = longint'($signed(i_raw));
        qv = longint'($signed(q_raw));
        v  = want_q ? (iv * s + qv * c) : (iv * c - qv * s);
        v  = (v + 64'sd16384) >>> 15;
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic exp_t expect_vec(input ph_vec_t ph, input dat_vec_t di, input dat_vec_t dq);
        exp_t e;
        for (int n = 0; n < NL; n++) begin
            e.ei[n] = model_rot(ph[n], di[n], dq[n], 1'b0);
            e.eq[n] = model_rot(ph[n], di[n], dq[n], 1'b1);
        end
        return e;
    endfunction

    task automatic apply(input ph_vec_t ph, input dat_vec_t di, input dat_vec_t dq);
        phase_vals = ph;
        data_i_in  = di;
        data_q_in  = dq;
    endtask

    task automatic apply_all(input logic [13:0] ph, input logic [15:0] i, input logic [15:0] q);
        ph_vec_t  p;
        dat_vec_t di, dq;
        for (int n = 0; n < NL; n++) begin
            p[n] = ph; di[n] = i; dq[n] = q;
        end
        apply(p, di, dq);
    endtask

    task automatic test_reset();
        ph_vec_t  p;
        dat_vec_t di, dq;
        for (int n = 0; n < NL; n++) begin
            p[n] = 14'($urandom); di[n] = 16'($urandom) | 16'h0100; dq[n] = 16'($urandom) | 16'h0100;
        end
        apply(p, di, dq);
        #2 reset = 1'b1;
        #1;
        n_checks += 2;
        if (data_i_rot !== '0) begin n_errors++; $display("FAIL reset_async_i got=%h want=0", data_i_rot); end
        if (data_q_rot !== '0) begin n_errors++; $display("FAIL reset_async_q got=%h want=0", data_q_rot); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk100);
            n_checks += 2;
            if (data_i_rot !== '0) begin n_errors++; $display("FAIL reset_hold_i cyc=%0d got=%h want=0", c, data_i_rot); end
            if (data_q_rot !== '0) begin n_errors++; $display("FAIL reset_hold_q cyc=%0d got=%h want=0", c, data_q_rot); end
        end
        apply_all(14'h0, 16'h0, 16'h0);
        @(negedge clk100);
        reset = 1'b0;
        $display("reset: async clear and hold checked");
    endtask

    task automatic test_identity();
        @(negedge clk100);
        apply_all(14'h0000, 16'd1000, -16'sd500);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk100);
            for (int n = 0; n < NL; n++) begin
                n_checks += 2;
                if (c < 3) begin
                    if (data_i_rot[n] !== 16'h0) begin n_errors++; $display("FAIL ident_early_i lane=%0d cyc=%0d got=%0d want=0", n, c, $signed(data_i_rot[n])); end
                    if (data_q_rot[n] !== 16'h0) begin n_errors++; $display("FAIL ident_early_q lane=%0d cyc=%0d got=%0d want=0", n, c, $signed(data_q_rot[n])); end
                end else begin
                    if (data_i_rot[n] !== 16'sd1000) begin n_errors++; $display("FAIL ident_i lane=%0d got=%0d want=1000", n, $signed(data_i_rot[n])); end
                    if (data_q_rot[n] !== -16'sd500) begin n_errors++; $display("FAIL ident_q lane=%0d got=%0d want=-500", n, $signed(data_q_rot[n])); end
                end
            end
        end
        $display("identity: phase 0, I=1000 Q=-500, latency 3 checked");
    endtask

    // Directed vectors with hand-derived results: quadrature steps, saturation, phase LSBs.
    task automatic test_directed();
        logic [13:0] t_ph [9] = '{14'h1000, 14'h2000, 14'h3000, 14'h0800, 14'h2000, 14'h0800, 14'h000F, 14'h100F, 14'h0000};
        int t_i  [9] = '{1000, 1000, 1000, 32767, -32768, -32768, 1000, 1000, -32768};
        int t_q  [9] = '{-500, -500, -500, -32768, 0, 32767, -500, -500, -32768};
        int r_i  [9] = '{500, -1000, -500, 32767, 32767, -32768, 1000, 500, -32767};
        int r_q  [9] = '{1000, 500, -1000, -1, 0, -1, -500, 1000, -32767};
        for (int e = 0; e < 9; e++) begin
            @(negedge clk100);
            apply_all(t_ph[e], 16'(t_i[e]), 16'(t_q[e]));
            repeat (3) @(negedge clk100);
            for (int n = 0; n < NL; n++) begin
                n_checks += 2;
                if (data_i_rot[n] !== 16'(r_i[e])) begin n_errors++; $display("FAIL directed_i vec=%0d lane=%0d got=%0d want=%0d", e, n, $signed(data_i_rot[n]), r_i[e]); end
                if (data_q_rot[n] !== 16'(r_q[e])) begin n_errors++; $display("FAIL directed_q vec=%0d lane=%0d got=%0d want=%0d", e, n, $signed(data_q_rot[n]), r_q[e]); end
            end
            $display("directed: vec=%0d phase=%h I=%0d Q=%0d", e, t_ph[e], t_i[e], t_q[e]);
        end
    endtask

    // Lane n: phase n*0x1000, I/Q ramps by n per clock; every lane checked every clock.
    task automatic test_lane_ramp();
        exp_t     q[$];
        exp_t     e;
        ph_vec_t  p;
        dat_vec_t di, dq;
        int       base_i [NL];
        int       base_q [NL];
        for (int n = 0; n < NL; n++) begin
            base_i[n] = int'($urandom_range(0, 20000)) - 10000;
            base_q[n] = int'($urandom_range(0, 20000)) - 10000;
        end
        for (int t = 0; t < 33; t++) begin
            @(negedge clk100);
            if (q.size() == 3) begin
                e = q.pop_front();
                for (int n = 0; n < NL; n++) begin
                    n_checks += 2;
                    if (data_i_rot[n] !== e.ei[n]) begin n_errors++; $display("FAIL ramp_i t=%0d lane=%0d got=%0d want=%0d", t, n, $signed(data_i_rot[n]), $signed(e.ei[n])); end
                    if (data_q_rot[n] !== e.eq[n]) begin n_errors++; $display("FAIL ramp_q t=%0d lane=%0d got=%0d want=%0d", t, n, $signed(data_q_rot[n]), $signed(e.eq[n])); end
                end
                $display("ramp: t=%0d lane0 I=%0d Q=%0d", t, $signed(data_i_rot[0]), $signed(data_q_rot[0]));
            end
            for (int n = 0; n < NL; n++) begin
                p[n]  = 14'(n * 32'h1000);
                di[n] = 16'(base_i[n] + n * t);
                dq[n] = 16'(base_q[n] + n * t);
            end
            apply(p, di, dq);
            q.push_back(expect_vec(p, di, dq));
        end
    endtask

    // Random phases/data with occasional full-scale values; phase LSBs scrambled
    // on the DUT side while the reference sees them cleared.
    task automatic test_random();
        exp_t     q[$];
        exp_t     e;
        ph_vec_t  p, p_ref;
        dat_vec_t di, dq;
        for (int t = 0; t < 63; t++) begin
            @(negedge clk100);
            if (q.size() == 3) begin
                e = q.pop_front();
                for (int n = 0; n < NL; n++) begin
                    n_checks += 2;
                    if (data_i_rot[n] !== e.ei[n]) begin n_errors++; $display("FAIL rand_i t=%0d lane=%0d got=%0d want=%0d", t, n, $signed(data_i_rot[n]), $signed(e.ei[n])); end
                    if (data_q_rot[n] !== e.eq[n]) begin n_errors++; $display("FAIL rand_q t=%0d lane=%0d got=%0d want=%0d", t, n, $signed(data_q_rot[n]), $signed(e.eq[n])); end
                end
                $display("random: t=%0d lane0 I=%0d Q=%0d", t, $signed(data_i_rot[0]), $signed(data_q_rot[0]));
            end
            for (int n = 0; n < NL; n++) begin
                p[n]     = 14'($urandom);
                p_ref[n] = p[n] & 14'h3FF0;
                di[n]    = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                dq[n]    = ($urandom_range(0, 7) == 0) ? 16'h7FFF : 16'($urandom);
            end
            apply(p, di, dq);
            q.push_back(expect_vec(p_ref, di, dq));
        end
    endtask

    task automatic test_reset_midstream();
        ph_vec_t  p;
        dat_vec_t di, dq;
        exp_t     e;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk100);
            apply_all(14'($urandom), 16'($urandom) | 16'h0400, 16'($urandom) | 16'h0400);
        end
        @(posedge clk100);
        #2 reset = 1'b1;
        #1;
        n_checks += 2;
        if (data_i_rot !== '0) begin n_errors++; $display("FAIL midreset_i got=%h want=0", data_i_rot); end
        if (data_q_rot !== '0) begin n_errors++; $display("FAIL midreset_q got=%h want=0", data_q_rot); end
        for (int n = 0; n < NL; n++) begin
            p[n] = 14'h0000; di[n] = 16'(1000 + 7 * n); dq[n] = -16'sd500;
        end
        @(negedge clk100);
        apply(p, di, dq);
        e = expect_vec(p, di, dq);
        @(negedge clk100);
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk100);
            for (int n = 0; n < NL; n++) begin
                n_checks += 2;
                if (c < 3) begin
                    if (data_i_rot[n] !== 16'h0) begin n_errors++; $display("FAIL postreset_early_i lane=%0d cyc=%0d got=%0d want=0", n, c, $signed(data_i_rot[n])); end
                    if (data_q_rot[n] !== 16'h0) begin n_errors++; $display("FAIL postreset_early_q lane=%0d cyc=%0d got=%0d want=0", n, c, $signed(data_q_rot[n])); end
                end else begin
                    if (data_i_rot[n] !== e.ei[n]) begin n_errors++; $display("FAIL postreset_i lane=%0d got=%0d want=%0d", n, $signed(data_i_rot[n]), $signed(e.ei[n])); end
                    if (data_q_rot[n] !== e.eq[n]) begin n_errors++; $display("FAIL postreset_q lane=%0d got=%0d want=%0d", n, $signed(data_q_rot[n]), $signed(e.eq[n])); end
                end
            end
        end
        $display("reset_midstream: flush and 3-clock restart checked");
    endtask

    initial begin
        apply_all(14'h0, 16'h0, 16'h0);
        test_reset();
        test_identity();
        test_directed();
        test_lane_ramp();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
